// File: rtl/pe_fanin_arbiter_pkg.sv
// Shared types and helpers for the PE forward-token fan-in path.
//
// Contents:
//   MAX_LINK / LINK_IDX_W  upper bound on requesters and the width of a link index
//   arb_state_t            fan-in arbiter FSM state
//   fwd_flags_t            forward token control flags {v, a, r, c}
//   bwd_tok_t              backward token {n, t, v, c}
//   rr_pick()              round-robin one-hot pick over up to MAX_LINK requesters
//
// Forward token data width is a per-instance parameter, so the data field is
// carried next to fwd_flags_t rather than inside it.
package pe_fanin_arbiter_pkg;

  localparam int MAX_LINK   = 8;
  localparam int LINK_IDX_W = 3;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic v;
    logic a;
    logic r;
    logic c;
  } fwd_flags_t;

  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } bwd_tok_t;

  // First set bit of req found scanning from last+1 upward, wrapping modulo num.
  // The link at 'last' is visited last, so it has the lowest priority.
  function automatic logic [MAX_LINK-1:0] rr_pick(
    input logic [MAX_LINK-1:0]   req,
    input logic [LINK_IDX_W-1:0] last,
    input int                    num
  );
    logic [MAX_LINK-1:0] gnt;
    logic                found;
    int                  idx;
    gnt   = '0;
    found = 1'b0;
    for (int i = 1; i <= MAX_LINK; i++) begin
      idx = (int'(last) + i) % num;
      if ((i <= num) && !found && req[idx[LINK_IDX_W-1:0]]) begin
        gnt[idx[LINK_IDX_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/pe_fanin_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter, shared with other PE blocks.
//
// Ports:
//   i_req   NUM_LINK    request vector
//   i_last  LINK_IDX_W  index of the most recent winner (lowest priority)
//   o_gnt   NUM_LINK    one-hot grant, all zero when nothing requests
module rr_arbiter
  import pe_fanin_arbiter_pkg::*;
#(
  parameter int NUM_LINK = 5
) (
  input  logic [NUM_LINK-1:0]   i_req,
  input  logic [LINK_IDX_W-1:0] i_last,
  output logic [NUM_LINK-1:0]   o_gnt
);

  logic [MAX_LINK-1:0] w_req_ext;
  logic [MAX_LINK-1:0] w_gnt_ext;

  assign w_req_ext = MAX_LINK'(i_req);
  assign w_gnt_ext = rr_pick(w_req_ext, i_last, NUM_LINK);
  assign o_gnt     = w_gnt_ext[NUM_LINK-1:0];

endmodule

// File: rtl/pe_fanin_arbiter.sv
// Message-level round-robin fan-in arbiter for the PE forward-token path.
// A link wins with an acquire token and owns the path until its release
// token is accepted. The output is a one-entry registered stage with nack
// backpressure; a watchdog reclaims the path from a stalled grantee.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARB_IDLE  | no owner; pick next acquiring link round-robin, nack all
// ARB_GRANT | one owner; accept its tokens, nack everyone else
//
// Ports:
//   clock, reset             clock, async active-low reset
//   I_FTk_v/a/r/c/d          per-link forward tokens (data packed per link)
//   O_BTk_n/t/v/c            per-link backward tokens (nack, routed t/v/c)
//   O_FTk_v/a/r/c/d          registered arbitrated forward token
//   I_BTk_n/t/v/c            downstream backward token
//   O_Grant                  one-hot owner, zero in ARB_IDLE
//   O_Err                    one-cycle pulse on watchdog release
module pe_fanin_arbiter
  import pe_fanin_arbiter_pkg::*;
#(
  parameter int WIDTH_DATA    = 32,
  parameter int NUM_LINK      = 5,
  parameter int TIMEOUT       = 64,
  parameter int WIDTH_TIMEOUT = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_LINK-1:0]            I_FTk_v,
  input  logic [NUM_LINK-1:0]            I_FTk_a,
  input  logic [NUM_LINK-1:0]            I_FTk_r,
  input  logic [NUM_LINK-1:0]            I_FTk_c,
  input  logic [NUM_LINK*WIDTH_DATA-1:0] I_FTk_d,
  output logic [NUM_LINK-1:0]            O_BTk_n,
  output logic [NUM_LINK-1:0]            O_BTk_t,
  output logic [NUM_LINK-1:0]            O_BTk_v,
  output logic [NUM_LINK-1:0]            O_BTk_c,
  output logic                           O_FTk_v,
  output logic                           O_FTk_a,
  output logic                           O_FTk_r,
  output logic                           O_FTk_c,
  output logic [WIDTH_DATA-1:0]          O_FTk_d,
  input  logic                           I_BTk_n,
  input  logic                           I_BTk_t,
  input  logic                           I_BTk_v,
  input  logic                           I_BTk_c,
  output logic [NUM_LINK-1:0]            O_Grant,
  output logic                           O_Err
);

  localparam logic [LINK_IDX_W-1:0] LAST_RST = LINK_IDX_W'(NUM_LINK - 1);
  localparam logic [WIDTH_TIMEOUT-1:0] WDOG_LAST =
    WIDTH_TIMEOUT'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  arb_state_t                r_state;
  logic [NUM_LINK-1:0]       r_grant;
  logic [LINK_IDX_W-1:0]     r_last;
  fwd_flags_t                r_ft;
  logic [WIDTH_DATA-1:0]     r_ft_d;
  logic [WIDTH_TIMEOUT-1:0]  r_wdog;
  logic                      r_err;

  bwd_tok_t                  w_bwd;
  fwd_flags_t                w_g;
  logic [WIDTH_DATA-1:0]     w_g_d;
  logic [LINK_IDX_W-1:0]     w_g_idx;
  logic [NUM_LINK-1:0]       w_req;
  logic [NUM_LINK-1:0]       w_pick;
  logic                      w_can_load;
  logic                      w_accept;
  logic                      w_timeout;

  assign w_bwd = '{n: I_BTk_n, t: I_BTk_t, v: I_BTk_v, c: I_BTk_c};

  // The output stage can take a new token when empty or when its current
  // token leaves this cycle.
  assign w_can_load = !r_ft.v || !w_bwd.n;

  assign w_req = I_FTk_v & I_FTk_a;

  rr_arbiter #(
    .NUM_LINK (NUM_LINK)
  ) u_rr (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_pick)
  );

  // Grant is one-hot (zero in ARB_IDLE), so a plain select of the owner.
  always_comb begin
    w_g     = '0;
    w_g_d   = '0;
    w_g_idx = '0;
    for (int l = 0; l < NUM_LINK; l++) begin
      if (r_grant[l]) begin
        w_g.v   = I_FTk_v[l];
        w_g.a   = I_FTk_a[l];
        w_g.r   = I_FTk_r[l];
        w_g.c   = I_FTk_c[l];
        w_g_d   = I_FTk_d[l*WIDTH_DATA +: WIDTH_DATA];
        w_g_idx = LINK_IDX_W'(l);
      end
    end
  end

  assign w_accept  = (r_state == ARB_GRANT) && w_g.v && w_can_load;
  assign w_timeout = (TIMEOUT != 0) && (r_wdog == WDOG_LAST);

  // Only the owner with room in the output stage escapes the nack; in
  // ARB_IDLE and during reset the grant is zero, so every valid link is nacked.
  assign O_BTk_n = I_FTk_v & ~(r_grant & {NUM_LINK{w_can_load}});
  assign O_BTk_t = {NUM_LINK{w_bwd.t}} & r_grant;
  assign O_BTk_v = {NUM_LINK{w_bwd.v}} & r_grant;
  assign O_BTk_c = {NUM_LINK{w_bwd.c}} & r_grant;

  assign O_FTk_v = r_ft.v;
  assign O_FTk_a = r_ft.a;
  assign O_FTk_r = r_ft.r;
  assign O_FTk_c = r_ft.c;
  assign O_FTk_d = r_ft_d;
  assign O_Grant = r_grant;
  assign O_Err   = r_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_last  <= LAST_RST;
      r_ft    <= '0;
      r_ft_d  <= '0;
      r_wdog  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;

      // Output stage: load on accept, otherwise drain when the held token
      // has left (or there was none). A pending token survives a timeout.
      if (w_accept) begin
        r_ft   <= '{v: 1'b1, a: w_g.a, r: w_g.r, c: w_g.c};
        r_ft_d <= w_g_d;
      end else if (w_can_load) begin
        r_ft   <= '0;
        r_ft_d <= '0;
      end

      case (r_state)
        ARB_IDLE: begin
          r_wdog <= '0;
          if (|w_pick) begin
            r_grant <= w_pick;
            r_state <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (w_accept) begin
            r_wdog <= '0;
            if (w_g.r) begin
              r_state <= ARB_IDLE;
              r_grant <= '0;
              r_last  <= w_g_idx;
            end
          end else if (w_timeout) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_last  <= w_g_idx;
            r_wdog  <= '0;
            r_err   <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_fanin_arbiter.sv
module tb_pe_fanin_arbiter;

  localparam int NL = 5;
  localparam int WD = 32;

  logic              clock;
  logic              reset;
  logic [NL-1:0]     I_FTk_v, I_FTk_a, I_FTk_r, I_FTk_c;
  logic [NL*WD-1:0]  I_FTk_d;
  logic [NL-1:0]     O_BTk_n, O_BTk_t, O_BTk_v, O_BTk_c;
  logic              O_FTk_v, O_FTk_a, O_FTk_r, O_FTk_c;
  logic [WD-1:0]     O_FTk_d;
  logic              I_BTk_n, I_BTk_t, I_BTk_v, I_BTk_c;
  logic [NL-1:0]     O_Grant;
  logic              O_Err;

  int checks = 0;
  int errors = 0;

  pe_fanin_arbiter #(
    .WIDTH_DATA    (WD),
    .NUM_LINK      (NL),
    .TIMEOUT       (4),
    .WIDTH_TIMEOUT (8)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .I_FTk_v (I_FTk_v),
    .I_FTk_a (I_FTk_a),
    .I_FTk_r (I_FTk_r),
    .I_FTk_c (I_FTk_c),
    .I_FTk_d (I_FTk_d),
    .O_BTk_n (O_BTk_n),
    .O_BTk_t (O_BTk_t),
    .O_BTk_v (O_BTk_v),
    .O_BTk_c (O_BTk_c),
    .O_FTk_v (O_FTk_v),
    .O_FTk_a (O_FTk_a),
    .O_FTk_r (O_FTk_r),
    .O_FTk_c (O_FTk_c),
    .O_FTk_d (O_FTk_d),
    .I_BTk_n (I_BTk_n),
    .I_BTk_t (I_BTk_t),
    .I_BTk_v (I_BTk_v),
    .I_BTk_c (I_BTk_c),
    .O_Grant (O_Grant),
    .O_Err   (O_Err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int l, input logic v, input logic a, input logic r,
                       input logic c, input logic [WD-1:0] d);
    I_FTk_v[l] = v;
    I_FTk_a[l] = a;
    I_FTk_r[l] = r;
    I_FTk_c[l] = c;
    I_FTk_d[l*WD +: WD] = d;
  endtask

  initial begin
    clock   = 1'b0;
    reset   = 1'b1;
    I_FTk_v = '0; I_FTk_a = '0; I_FTk_r = '0; I_FTk_c = '0; I_FTk_d = '0;
    I_BTk_n = 1'b0; I_BTk_t = 1'b0; I_BTk_v = 1'b0; I_BTk_c = 1'b0;

    // ---- reset state ----
    #1 reset = 1'b0;
    drive(2, 1, 0, 0, 0, 32'h0);
    drive(4, 1, 0, 0, 0, 32'h0);
    I_BTk_t = 1'b1;
    #1;
    chk("rst_btk_n", 32'(O_BTk_n), 32'h14);
    chk("rst_btk_t", 32'(O_BTk_t), 32'h0);
    chk("rst_ftk_v", 32'(O_FTk_v), 32'h0);
    chk("rst_grant", 32'(O_Grant), 32'h0);
    chk("rst_err",   32'(O_Err),   32'h0);
    cyc();
    cyc();
    chk("rst_grant_hold", 32'(O_Grant), 32'h0);
    drive(2, 0, 0, 0, 0, 32'h0);
    drive(4, 0, 0, 0, 0, 32'h0);
    I_BTk_t = 1'b0;
    reset = 1'b1;

    // ---- round robin: links 0,1,3 with single-token messages ----
    drive(0, 1, 1, 1, 0, 32'hA0);
    drive(1, 1, 1, 1, 0, 32'hA1);
    drive(3, 1, 1, 1, 0, 32'hA3);
    #1;
    chk("rr_idle_nack", 32'(O_BTk_n), 32'h0B);
    cyc();
    chk("rr_grant0", 32'(O_Grant), 32'h01);
    chk("rr_btk_n0", 32'(O_BTk_n), 32'h0A);
    cyc();
    drive(0, 0, 0, 0, 0, 32'h0);
    chk("rr_d0",        O_FTk_d,           32'hA0);
    chk("rr_r0",        32'(O_FTk_r),      32'h1);
    chk("rr_one_cycle", 32'(O_Grant),      32'h0);
    cyc();
    chk("rr_grant1", 32'(O_Grant), 32'h02);
    chk("rr_empty",  32'(O_FTk_v), 32'h0);
    cyc();
    drive(1, 0, 0, 0, 0, 32'h0);
    drive(0, 1, 1, 1, 0, 32'hB0);
    chk("rr_d1", O_FTk_d, 32'hA1);
    cyc();
    chk("rr_grant3", 32'(O_Grant), 32'h08);
    cyc();
    drive(3, 0, 0, 0, 0, 32'h0);
    drive(1, 1, 1, 1, 0, 32'hB1);
    chk("rr_d3", O_FTk_d, 32'hA3);
    cyc();
    chk("rr_grant0_again", 32'(O_Grant), 32'h01);
    cyc();
    drive(0, 0, 0, 0, 0, 32'h0);
    chk("rr_dB0", O_FTk_d, 32'hB0);
    cyc();
    chk("rr_grant1_again", 32'(O_Grant), 32'h02);
    cyc();
    drive(1, 0, 0, 0, 0, 32'h0);
    chk("rr_dB1", O_FTk_d, 32'hB1);
    cyc();

    // ---- single requester: link 2, three-token message ----
    drive(2, 1, 1, 0, 0, 32'h11);
    cyc();
    chk("s_grant", 32'(O_Grant), 32'h04);
    cyc();
    drive(2, 1, 0, 0, 0, 32'h22);
    chk("s_d0", O_FTk_d,      32'h11);
    chk("s_a0", 32'(O_FTk_a), 32'h1);
    cyc();
    drive(2, 1, 0, 1, 0, 32'h33);
    chk("s_d1", O_FTk_d, 32'h22);
    cyc();
    drive(2, 0, 0, 0, 0, 32'h0);
    chk("s_d2",   O_FTk_d,       32'h33);
    chk("s_r2",   32'(O_FTk_r),  32'h1);
    chk("s_idle", 32'(O_Grant),  32'h0);
    cyc();
    chk("s_empty", 32'(O_FTk_v), 32'h0);

    // ---- competing link 4 during link 1 message, with backpressure ----
    drive(1, 1, 1, 0, 0, 32'hC0);
    cyc();
    drive(4, 1, 1, 1, 0, 32'hD4);
    I_BTk_t = 1'b1;
    #1;
    chk("c_grant1", 32'(O_Grant), 32'h02);
    chk("c_btk_t",  32'(O_BTk_t), 32'h02);
    chk("c_nack4",  32'(O_BTk_n), 32'h10);
    I_BTk_t = 1'b0;
    cyc();
    drive(1, 1, 0, 0, 0, 32'hC1);
    I_BTk_n = 1'b1;
    #1;
    chk("bp_d0",     O_FTk_d,       32'hC0);
    chk("bp_nack_g", 32'(O_BTk_n),  32'h12);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_hold_d",    O_FTk_d,      32'hC0);
      chk("bp_hold_v",    32'(O_FTk_v), 32'h1);
      chk("bp_hold_nack", 32'(O_BTk_n), 32'h12);
    end
    I_BTk_n = 1'b0;
    #1;
    chk("bp_accept_nack", 32'(O_BTk_n), 32'h10);
    cyc();
    drive(1, 1, 0, 1, 0, 32'hC2);
    chk("bp_d1",     O_FTk_d,      32'hC1);
    chk("bp_no_err", 32'(O_Err),   32'h0);
    chk("bp_grant",  32'(O_Grant), 32'h02);
    cyc();
    drive(1, 0, 0, 0, 0, 32'h0);
    #1;
    chk("c_d2",         O_FTk_d,      32'hC2);
    chk("c_idle",       32'(O_Grant), 32'h0);
    chk("c_idle_nack4", 32'(O_BTk_n), 32'h10);
    cyc();
    chk("c_grant4", 32'(O_Grant), 32'h10);
    cyc();
    drive(4, 0, 0, 0, 0, 32'h0);
    chk("c_d4", O_FTk_d, 32'hD4);
    cyc();

    // ---- watchdog: link 0 stalls, link 2 waits ----
    drive(0, 1, 1, 0, 0, 32'hE0);
    drive(2, 1, 1, 1, 0, 32'hE2);
    cyc();
    chk("w_grant0", 32'(O_Grant), 32'h01);
    cyc();
    drive(0, 0, 0, 0, 0, 32'h0);
    chk("w_d0", O_FTk_d, 32'hE0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("w_wait_err",   32'(O_Err),   32'h0);
      chk("w_wait_grant", 32'(O_Grant), 32'h01);
    end
    cyc();
    chk("w_err",       32'(O_Err),   32'h1);
    chk("w_grant_clr", 32'(O_Grant), 32'h0);
    cyc();
    chk("w_err_pulse", 32'(O_Err),   32'h0);
    chk("w_grant2",    32'(O_Grant), 32'h04);
    cyc();
    drive(2, 0, 0, 0, 0, 32'h0);
    chk("w_d2", O_FTk_d, 32'hE2);

    // ---- async reset mid-message ----
    drive(3, 1, 1, 0, 0, 32'hF3);
    cyc();
    chk("a_grant3", 32'(O_Grant), 32'h08);
    cyc();
    drive(3, 1, 0, 0, 0, 32'hF4);
    chk("a_v_before", 32'(O_FTk_v), 32'h1);
    #3 reset = 1'b0;
    #1;
    chk("a_v",     32'(O_FTk_v), 32'h0);
    chk("a_grant", 32'(O_Grant), 32'h0);
    chk("a_d",     O_FTk_d,      32'h0);
    chk("a_nack",  32'(O_BTk_n), 32'h08);
    drive(3, 0, 0, 0, 0, 32'h0);
    drive(1, 1, 1, 1, 0, 32'h71);
    drive(4, 1, 1, 1, 0, 32'h74);
    #2 reset = 1'b1;
    cyc();
    chk("a_first_link", 32'(O_Grant), 32'h02);
    cyc();
    drive(1, 0, 0, 0, 0, 32'h0);
    chk("a_d1", O_FTk_d, 32'h71);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_fanin_arbiter.md
Name: pe_fanin_arbiter

Overview:
- Message-level round-robin arbiter that shares one PE forward-token path (ALU operand input or link fan-in) among NUM_LINK requesters.
- A requester wins on an acquire token and keeps the path until its release token is accepted.
- The output is a one-entry registered stage with nack backpressure.
- A watchdog reclaims the path from a stalled grantee.

Parameters:
- WIDTH_DATA, 32, token data width.
- NUM_LINK, 5, number of requesters (2..8).
- TIMEOUT, 64, idle cycles tolerated in GRANT before forced release; 0 disables the watchdog.
- WIDTH_TIMEOUT, 8, watchdog counter width; must satisfy TIMEOUT < 2^WIDTH_TIMEOUT.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- I_FTk_v/a/r/c  in  NUM_LINK each  per-link forward valid/acquire/release/cond.
- I_FTk_d  in  NUM_LINK*WIDTH_DATA  per-link data; link l occupies bits [l*WIDTH_DATA +: WIDTH_DATA].
- O_BTk_n  out  NUM_LINK  per-link nack.
- O_BTk_t/v/c  out  NUM_LINK each  per-link backward term/valid/cond.
- O_FTk_v/a/r/c  out  1 each  arbitrated forward token flags (registered).
- O_FTk_d  out  WIDTH_DATA  arbitrated forward token data (registered).
- I_BTk_n/t/v/c  in  1 each  downstream backward token.
- O_Grant  out  NUM_LINK  one-hot current grant; all zero in IDLE.
- O_Err  out  1  one-cycle pulse on watchdog release.

Behaviour:
- Reset: state=IDLE, grant=0, last=NUM_LINK-1, output register empty (O_FTk_* = 0), wdog=0, O_Err=0.
- Combinational outputs during reset: O_BTk_n = I_FTk_v (every valid requester nacked); other O_BTk_* = 0.
- Downstream transfer happens when O_FTk_v && !I_BTk_n. If I_BTk_n is high, the output register holds its value.
- can_load = !O_FTk_v || !I_BTk_n.
- IDLE:
  - Requesters are links with v&&a. Pick the first one found scanning from last+1, wrapping modulo NUM_LINK.
  - Register the one-hot grant and go to GRANT next cycle.
  - No token is accepted in IDLE; every valid link is nacked.
  - A link valid without a is nacked indefinitely.
- GRANT, grantee g:
  - accept = I_FTk_v[g] && can_load.
  - O_BTk_n[g] = I_FTk_v[g] && !can_load. Every other valid link is nacked.
  - On accept, the output register loads {v=1, a, r, c, d} of link g. Latency is 1 cycle from accept to O_FTk_v.
  - If can_load and no accept, the output register clears to empty (v=0).
  - An accepted token with r=1 moves the state to IDLE and sets last=g.
  - A single-token message (a=r=1) holds the grant for exactly one GRANT cycle.
- Backward routing: O_BTk_t/v/c[l] = I_BTk_t/v/c & grant[l]. Non-granted links receive 0.
- Watchdog (TIMEOUT>0):
  - In GRANT, wdog increments on each cycle with no accept and clears on accept.
  - When wdog==TIMEOUT-1 and there is no accept: go to IDLE, set last=g, clear wdog, pulse O_Err for 1 cycle.
  - A pending token in the output register is still delivered.
  - Accept has priority over timeout in the same cycle.
- Simultaneous requests: round-robin fairness; a link that just released has lowest priority next arbitration.
- Asserting reset mid-message discards the output register and the grant immediately (asynchronous); no partial state survives.
- Throughput: 1 token/cycle during GRANT under no backpressure. Arbitration costs 1 bubble cycle per message.

Decomposition:
- Shared package pkg_en additions:
  - arb_state_t enum {ARB_IDLE, ARB_GRANT}.
  - Packed structs fwd_tok_t {v,a,r,c,d} and bwd_tok_t {n,t,v,c}.
  - Function rr_pick(req, last) returning a one-hot.
- One sub-module: rr_arbiter. Purely combinational; inputs req[NUM_LINK] and last; output one-hot gnt. Reused elsewhere in the PE.
- FSM, output register and watchdog live in pe_fanin_arbiter.

Test Plan:
- Single requester: link 2 sends a=1 d=0x11, then d=0x22, then r=1 d=0x33, no nack.
  - Expect O_Grant=0b00100 one cycle after the request.
  - Expect O_FTk_d sequence 0x11, 0x22, 0x33 on consecutive cycles.
  - Expect IDLE after the r token.
- Round robin: links 0, 1, 3 all request with 1-token messages (a=r=1).
  - Expect grants in order 0, 1, 3, then 0 again when link 0 re-requests alongside 1.
  - Expect no link starved.
- Backpressure: I_BTk_n=1 for 3 cycles mid-message.
  - Expect O_FTk held constant, O_BTk_n[g]=1 and no data loss.
  - Expect the token order preserved once nack drops.
- Competing link while busy: link 4 requests during link 1's message.
  - Expect O_BTk_n[4]=1 until link 1's release.
  - Expect link 4 granted one cycle after IDLE is re-entered.
- Watchdog, TIMEOUT=4: link 0 acquires, then holds v=0.
  - Expect O_Err=1 for exactly 1 cycle 4 cycles after the last accept, grant cleared.
  - Expect a waiting link 2 granted next.
- Async reset: assert reset low mid-message with O_FTk_v=1.
  - Expect O_FTk_v=0 and O_Grant=0 immediately, without a clock edge.
  - After release, expect the first arbitration to start at link 0.
